chunked_as: RTL and testbench
=============================

# chunked_as

Parametrised, multi-cycle two's-complement adder/subtractor computing `r = a + b` or `r = a - b` over WIDTH bits, CHUNK bits per clock, with valid/ready handshakes on both sides. It generalises the team's fixed 8-bit combinational adder/subtractor: arbitrary width, a bounded per-cycle carry chain, registered carry-out/overflow flags and optional saturation. It sits between an operand producer and a result consumer that may each stall.

## Interface
- `WIDTH`, 8: operand and result width. Must be ≥ 2.
- `CHUNK`, 2: bits processed per cycle. Must be ≥ 1 and divide WIDTH; otherwise elaboration fails. NCH = WIDTH/CHUNK.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand request valid.
- `in_ready` output 1: block can accept a request (high only in IDLE).
- `a` input WIDTH: signed operand A.
- `b` input WIDTH: signed operand B.
- `opcode` input 1: 0 = add, 1 = subtract.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `r` output WIDTH: signed result.
- `cout` output 1: carry out of MSB. For subtract, 1 = no borrow.
- `overflow` output 1: signed overflow = carry-into-MSB XOR carry-out-of-MSB.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: `out_valid`=0, `r`=0, `cout`=0, `overflow`=0. `in_ready`=1, since it is decoded from IDLE.
- IDLE, on `in_valid && in_ready`:
  - latch `a` and `b ^ {WIDTH{opcode}}`;
  - carry register ← `opcode`;
  - chunk index ← 0;
  - → BUSY.
- BUSY, each cycle:
  - add chunk[index] of both latched operands plus the carry;
  - write the sum into working bits [index·CHUNK +: CHUNK];
  - update the carry;
  - index increments.
- BUSY, on the last chunk (index = NCH−1):
  - capture carry-in and carry-out of bit WIDTH−1;
  - load `r`, `cout` and `overflow` into output registers;
  - → DONE.
- DONE: `out_valid`=1. `r`/`cout`/`overflow` are held stable until `out_ready`, then → IDLE.
- `r`/`cout`/`overflow` keep their value after handshake until the next result loads.
- Input ports are ignored outside the IDLE accept cycle. Operand changes during BUSY have no effect.
- Arithmetic is modulo 2^WIDTH (wrap), unless saturation is configured.
- The chunk index counter is max($clog2(NCH),1) bits wide. It wraps only through reset to 0 on accept.
- Reset asserted in any state: immediate return to IDLE with reset values. The in-flight operation is discarded and no result is produced.

## Timing
- Accept at edge E. Chunk i is processed at edge E+1+i. `out_valid` rises after edge E+NCH.
- Latency from accept to `out_valid` is NCH cycles.
- With `out_ready` held high: DONE lasts 1 cycle, IDLE 1 cycle. Minimum initiation interval is NCH+2 cycles.
- No accept in DONE even if `out_ready` is high.
- Critical path is one CHUNK-bit ripple plus register.
- CHUNK = WIDTH degenerates to a 1-cycle BUSY.

## Configuration
- `AS_SATURATE_EN` defined: when `overflow`=1, `r` is clamped to the most positive value (result would be positive, i.e. sign of `a` = 0) or the most negative value (sign of `a` = 1). `overflow` and `cout` are still reported unchanged.
- `AS_SATURATE_EN` undefined: `r` is the wrapped sum.

## Structure
- Package `as_pkg`:
  - opcode constants `OP_ADD`=0, `OP_SUB`=1;
  - FSM state enum (IDLE, BUSY, DONE).
- Sub-module `as_chunk`: CHUNK-bit ripple adder slice. Inputs: x, y, cin. Outputs: sum, cout, and carry into its top bit (used for overflow on the last chunk).
- Top contains the FSM, counter, operand and output registers, and the saturation mux.

## Test plan
Run at WIDTH=8, CHUNK=2 (NCH=4) unless stated.
- 100 + 27 → `r`=127, `cout`=0, `overflow`=0. `out_valid` exactly 4 cycles after the accept edge.
- 100 + 28 → `overflow`=1, `cout`=0. `r`=−128 wrapped; `r`=127 with `AS_SATURATE_EN`.
- 5 − 7 → `r`=−2 (0xFE), `cout`=0. Then 7 − 5 → `r`=2, `cout`=1. Both with `overflow`=0.
- −128 − 1 → `overflow`=1, `cout`=1. `r`=127 wrapped; `r`=−128 with `AS_SATURATE_EN`.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE with `in_valid`=1 and new operands → `r` and flags stable, `in_ready`=0, and the new request is accepted only after the result handshake.
- Reset: drop `rst_n` at the 2nd BUSY cycle → outputs go to reset values immediately, `in_ready`=1, and no `out_valid` pulse occurs. Also repeat the add test at WIDTH=16, CHUNK=16 → latency 1.

Source files
------------

// File: rtl/as_pkg.sv
// Shared opcode encodings and FSM state type for the chunked adder/subtractor.
// Imported by chunked_as; holds no logic.
package as_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/as_chunk.sv
// CHUNK-bit ripple adder slice, purely combinational (zero latency, no flow control).
// ctop is the carry into the slice's top bit, used for signed overflow on the last chunk.
module as_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             ctop
);

  logic [CHUNK:0] w_full;

  assign w_full = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  assign sum    = w_full[CHUNK-1:0];
  assign cout   = w_full[CHUNK];
  // Sum bit = x ^ y ^ carry-in, so the carry into the top bit falls out directly.
  assign ctop   = w_full[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/chunked_as.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per cycle; result NCH=WIDTH/CHUNK cycles after accept.
// Accepts only in IDLE; result held in DONE until out_ready. Define AS_SATURATE_EN to clamp on overflow.
module chunked_as
  import as_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             overflow
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $fatal(1, "chunked_as: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_r;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_xa;
  logic [CHUNK-1:0] w_yb;
  logic [CHUNK-1:0] w_csum;
  logic             w_cout;
  logic             w_ctop;
  logic             w_ovf;
  logic [WIDTH-1:0] w_work;
  logic [WIDTH-1:0] w_rout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: begin
        if (r_idx == IW'(NCH - 1)) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_xa = r_a[r_idx*CHUNK +: CHUNK];
  assign w_yb = r_b[r_idx*CHUNK +: CHUNK];

  as_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (w_xa),
    .y    (w_yb),
    .cin  (r_carry),
    .sum  (w_csum),
    .cout (w_cout),
    .ctop (w_ctop)
  );

  // Working word with the current slice merged in, so the last chunk can load r directly.
  always_comb begin
    w_work                         = r_sum;
    w_work[r_idx*CHUNK +: CHUNK]   = w_csum;
  end

  assign w_ovf = w_ctop ^ w_cout;

`ifdef AS_SATURATE_EN
  always_comb begin
    w_rout = w_work;
    if (w_ovf) w_rout = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign w_rout = w_work;
`endif

  // Subtract is a + ~b + 1: invert b at accept and seed the carry with the opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_r     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{opcode == OP_SUB}};
      r_carry <= (opcode == OP_SUB);
      r_idx   <= '0;
    end else if (r_state == BUSY) begin
      r_sum   <= w_work;
      r_carry <= w_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_r    <= w_rout;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign r         = r_r;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_chunked_as.sv
// Scoreboard bench: an 8-bit/2-bit-chunk instance and a 16-bit single-chunk instance,
// each checked against an integer-arithmetic reference model.
module tb_chunked_as;

  typedef struct {
    logic [15:0] r;
    logic        co;
    logic        ov;
    int          acc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv1 = 1'b0, or1 = 1'b1, op1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic        ir1, ov1, co1, of1;
  logic [7:0]  r1;

  logic        iv2 = 1'b0, or2 = 1'b1, op2 = 1'b0;
  logic [15:0] a2 = '0, b2 = '0;
  logic        ir2, ov2, co2, of2;
  logic [15:0] r2;

  chunked_as #(.WIDTH(8), .CHUNK(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .opcode(op1),
    .out_valid(ov1), .out_ready(or1), .r(r1), .cout(co1), .overflow(of1)
  );

  chunked_as #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .opcode(op2),
    .out_valid(ov2), .out_ready(or2), .r(r2), .cout(co2), .overflow(of2)
  );

  int   n_chk = 0, n_fail = 0, cyc = 0, rdy_mode = 0;
  exp_t q1[$], q2[$];
  logic pv1 = 1'b0, pv2 = 1'b0;

  task automatic chk(string name, longint act, longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic bad(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: signed/unsigned integer arithmetic on the operands' numeric values.
  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic op, int acc);
    exp_t   e;
    longint m  = longint'(1) << w;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint sr = op ? sa - sb : sa + sb;
    e.ov = (sr >= m / 2) || (sr < -(m / 2));
    e.co = op ? (ua >= ub) : (ua + ub >= m);
    sr   = ((sr % m) + m) % m;
`ifdef AS_SATURATE_EN
    if (e.ov) sr = (sa < 0) ? m / 2 : m / 2 - 1;
`endif
    e.r   = 16'(sr);
    e.acc = acc;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       or1 = 1'b1;
      1:       or1 = 1'($urandom_range(0, 1));
      default: or1 = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) pv1 = 1'b0;
    else begin
      if (iv1 && ir1) q1.push_back(model(8, {8'h00, a1}, {8'h00, b1}, op1, cyc + 1));
      if (ov1) begin
        chk("in_ready_low_in_done_1", ir1, 0);
        if (q1.size() == 0) bad("unexpected_out_valid_1");
        else begin
          if (!pv1) chk("latency_1", cyc - q1[0].acc, 4);
          chk("r_1", r1, q1[0].r);
          chk("cout_1", co1, q1[0].co);
          chk("overflow_1", of1, q1[0].ov);
          if (or1) void'(q1.pop_front());
        end
      end
      pv1 = ov1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) pv2 = 1'b0;
    else begin
      if (iv2 && ir2) q2.push_back(model(16, a2, b2, op2, cyc + 1));
      if (ov2) begin
        if (q2.size() == 0) bad("unexpected_out_valid_2");
        else begin
          if (!pv2) chk("latency_2", cyc - q2[0].acc, 1);
          chk("r_2", r2, q2[0].r);
          chk("cout_2", co2, q2[0].co);
          chk("overflow_2", of2, q2[0].ov);
          if (or2) void'(q2.pop_front());
        end
      end
      pv2 = ov2;
    end
  end

  task automatic send1(logic [7:0] a, logic [7:0] b, logic op);
    int t = 0;
    a1 = a; b1 = b; op1 = op; iv1 = 1'b1;
    @(negedge clk);
    while (!ir1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ir1) bad("accept_timeout_1");
    @(posedge clk);
    #1 iv1 = 1'b0;
  endtask

  task automatic send2(logic [15:0] a, logic [15:0] b, logic op);
    int t = 0;
    a2 = a; b2 = b; op2 = op; iv2 = 1'b1;
    @(negedge clk);
    while (!ir2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ir2) bad("accept_timeout_2");
    @(posedge clk);
    #1 iv2 = 1'b0;
  endtask

  task automatic drain1();
    int t = 0;
    while (q1.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q1.size() != 0) bad("drain_timeout_1");
    @(posedge clk);
    #1;
  endtask

  task automatic drain2();
    int t = 0;
    while (q2.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q2.size() != 0) bad("drain_timeout_2");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("reset_out_valid", ov1, 0);
    chk("reset_r", r1, 0);
    chk("reset_cout", co1, 0);
    chk("reset_overflow", of1, 0);
    chk("reset_in_ready", ir1, 1);
    chk("reset_r_2", r2, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    send1(8'd100, 8'd27, 1'b0);
    send1(8'd100, 8'd28, 1'b0);
    send1(8'd5, 8'd7, 1'b1);
    send1(8'd7, 8'd5, 1'b1);
    send1(8'h80, 8'd1, 1'b1);
    send1(8'hFF, 8'h00, 1'b1);
    send1(8'h7F, 8'h80, 1'b0);
    drain1();

    rdy_mode = 1;
    repeat (40) send1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    drain1();
    rdy_mode = 0;

    // Backpressure: result parked in DONE while a new request waits.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send1(8'd100, 8'd27, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    fork
      send1(8'd5, 8'd7, 1'b1);
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready", ir1, 0);
        chk("bp_out_valid", ov1, 1);
        chk("bp_r_held", r1, 127);
        rdy_mode = 0;
      end
    join
    drain1();

    // Reset in the second BUSY cycle discards the operation.
    send1(8'd3, 8'd4, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov1, 0);
    chk("midrst_r", r1, 0);
    chk("midrst_cout", co1, 0);
    chk("midrst_overflow", of1, 0);
    chk("midrst_in_ready", ir1, 1);
    q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send1(8'd100, 8'd27, 1'b0);
    drain1();

    send2(16'd100, 16'd27, 1'b0);
    send2(16'h8000, 16'd1, 1'b1);
    repeat (10) send2(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    drain2();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
